// File: rtl/rvm_muldiv_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply/divide unit:
// funct3 op encodings, FSM state encoding and a two's-complement helper.
package rvm_muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    // Magnitude of a value whose sign is already known; callers narrow it.
    function automatic logic [63:0] twos_abs(input logic [63:0] v,
                                             input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/rvm_muldiv_core.sv
// Shared iterative datapath: radix-2^MUL_STEP shift-add multiplier and
// restoring divider on one shift register, one adder and a step counter.
module rvm_muldiv_core #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 2
) (
    input  logic              clk_i,
    input  logic              clear_i,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   opa,
    input  logic [XLEN-1:0]   opb,
    output logic              last,
    output logic [2*XLEN-1:0] product,
    output logic [XLEN-1:0]   quotient,
    output logic [XLEN-1:0]   remainder
);

    localparam int AW = XLEN + MUL_STEP + 1;
    localparam int CW = $clog2(XLEN + 1);

    logic [2*XLEN-1:0]        sreg;
    logic [2*XLEN-1:0]        sreg_nxt;
    logic [CW-1:0]            cnt;
    logic [MUL_STEP-1:0]      digit;
    logic [XLEN+MUL_STEP-1:0] pp;
    logic [AW-1:0]            add_a;
    logic [AW-1:0]            add_b;
    logic [AW-1:0]            sum;
    logic                     cin;

    // One adder serves both modes: hi+partial product, or shifted rem-divisor.
    always_comb begin
        digit = sreg[MUL_STEP-1:0];
        pp    = (XLEN+MUL_STEP)'(opa) * (XLEN+MUL_STEP)'(digit);
        add_a = AW'(sreg[2*XLEN-1:XLEN]);
        add_b = AW'(pp);
        cin   = 1'b0;
        if (is_div) begin
            add_a = AW'(sreg[2*XLEN-1:XLEN-1]);
            add_b = ~AW'(opa);
            cin   = 1'b1;
        end
        sum = add_a + add_b + AW'(cin);
        if (!is_div) begin
            sreg_nxt = {sum[XLEN+MUL_STEP-1:0], sreg[XLEN-1:MUL_STEP]};
        end else if (sum[AW-1]) begin
            sreg_nxt = {sreg[2*XLEN-2:0], 1'b0};
        end else begin
            sreg_nxt = {sum[XLEN-1:0], sreg[XLEN-2:0], 1'b1};
        end
    end

    // Shift register and step counter: load operands, then iterate.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= {{XLEN{1'b0}}, opb};
            cnt  <= is_div ? CW'(XLEN) : CW'(XLEN / MUL_STEP);
        end else if (step) begin
            sreg <= sreg_nxt;
            cnt  <= cnt - CW'(1);
        end
    end

    assign last      = (cnt == CW'(1));
    assign product   = sreg;
    assign quotient  = sreg[XLEN-1:0];
    assign remainder = sreg[2*XLEN-1:XLEN];

endmodule

// File: rtl/rvm_muldiv_iter.sv
// Iterative M-extension unit: request/response handshakes, special-case
// detection, one-entry DIV/REM cache and sign fix-up around the core.
module rvm_muldiv_iter
    import rvm_muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 2,
    parameter int TAG_W    = 5
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  operand1_i,
    input  logic [XLEN-1:0]  operand2_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              load;
    logic              step;
    logic              fix_en;
    logic              last;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   rs1_q;
    logic [XLEN-1:0]   rs2_q;
    logic [TAG_W-1:0]  tag_q;

    logic              is_div;
    logic              rem_sel;
    logic              sgn1;
    logic              sgn2;
    logic              neg1;
    logic              neg2;
    logic              neg_q;
    logic [XLEN-1:0]   abs1;
    logic [XLEN-1:0]   abs2;

    logic              div0;
    logic              ovf;
    logic              hit;
    logic              special;
    logic              spec_q;
    logic [XLEN-1:0]   spec_val;
    logic [XLEN-1:0]   spec_res;

    logic              cache_v;
    logic              cache_sgn;
    logic [XLEN-1:0]   cache_rs1;
    logic [XLEN-1:0]   cache_rs2;
    logic [XLEN-1:0]   cache_quo;
    logic [XLEN-1:0]   cache_rem;

    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] prod_f;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;
    logic [XLEN-1:0]   quo_f;
    logic [XLEN-1:0]   rem_f;
    logic [XLEN-1:0]   fix_val;

    assign in_ready_o  = (state == S_IDLE) && !flush_i;
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (state == S_DONE);
    assign busy_o      = (state != S_IDLE);
    assign fix_en      = (state == S_FIX) && !flush_i;

    // Operand signedness, magnitudes and special-case detection.
    always_comb begin
        is_div  = op_q[2];
        rem_sel = op_q[1];
        sgn1    = !((op_q == OP_MULHU) || (op_q == OP_DIVU) ||
                    (op_q == OP_REMU));
        sgn2    = (op_q == OP_MUL) || (op_q == OP_MULH) ||
                  (op_q == OP_DIV) || (op_q == OP_REM);
        neg1    = sgn1 && rs1_q[XLEN-1];
        neg2    = sgn2 && rs2_q[XLEN-1];
        neg_q   = neg1 ^ neg2;
        abs1    = XLEN'(twos_abs(64'(rs1_q), neg1));
        abs2    = XLEN'(twos_abs(64'(rs2_q), neg2));
        div0    = is_div && (rs2_q == '0);
        ovf     = is_div && !op_q[0] && (rs1_q == MIN_NEG) &&
                  (rs2_q == '1);
        hit     = is_div && cache_v && (cache_rs1 == rs1_q) &&
                  (cache_rs2 == rs2_q) && (cache_sgn == !op_q[0]);
        special = div0 || ovf || hit;
        if (div0) begin
            spec_val = rem_sel ? rs1_q : '1;
        end else if (ovf) begin
            spec_val = rem_sel ? '0 : rs1_q;
        end else begin
            spec_val = rem_sel ? cache_rem : cache_quo;
        end
    end

    // Sign fix-up of the raw core results and final result selection.
    always_comb begin
        prod_f = neg_q ? (~product + (2*XLEN)'(1)) : product;
        quo_f  = neg_q ? (~quotient + XLEN'(1)) : quotient;
        rem_f  = neg1 ? (~remainder + XLEN'(1)) : remainder;
        if (is_div) begin
            fix_val = rem_sel ? rem_f : quo_f;
        end else if (op_q[1:0] == 2'b00) begin
            fix_val = prod_f[XLEN-1:0];
        end else begin
            fix_val = prod_f[2*XLEN-1:XLEN];
        end
    end

    rvm_muldiv_core #(
        .XLEN     (XLEN),
        .MUL_STEP (MUL_STEP)
    ) u_core (
        .clk_i     (clk_i),
        .clear_i   (clear_i),
        .load      (load),
        .step      (step),
        .is_div    (is_div),
        .opa       (abs2),
        .opb       (abs1),
        .last      (last),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and core controls; flush overrides every transition.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_PREP;
                end
            end
            S_PREP: begin
                load      = 1'b1;
                state_nxt = special ? S_FIX : S_RUN;
            end
            S_RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (flush_i) begin
            state_nxt = S_IDLE;
        end
    end

    // Request capture, special-case latch, result registers and cache.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            tag_q     <= '0;
            spec_q    <= 1'b0;
            spec_res  <= '0;
            result_o  <= '0;
            tag_o     <= '0;
            cache_v   <= 1'b0;
            cache_sgn <= 1'b0;
            cache_rs1 <= '0;
            cache_rs2 <= '0;
            cache_quo <= '0;
            cache_rem <= '0;
        end else begin
            if (accept) begin
                op_q  <= op_i;
                rs1_q <= operand1_i;
                rs2_q <= operand2_i;
                tag_q <= tag_i;
            end
            if (state == S_PREP) begin
                spec_q   <= special;
                spec_res <= spec_val;
            end
            if (fix_en) begin
                result_o <= spec_q ? spec_res : fix_val;
                tag_o    <= tag_q;
                if (!spec_q && is_div) begin
                    cache_v   <= 1'b1;
                    cache_sgn <= !op_q[0];
                    cache_rs1 <= rs1_q;
                    cache_rs2 <= rs2_q;
                    cache_quo <= quo_f;
                    cache_rem <= rem_f;
                end
            end
        end
    end

endmodule
